me_control: RTL and testbench

//  Sequencer for the 16-PE motion-estimation array and its downstream Comparator.
//  On start it sweeps all 16x16 candidate vectors and drives reference-block addresses
//  and per-PE accumulate enables. Each PE result is paired with its vector and handed
//  to the Comparator via pflag/PEready/CompStart. Signals done when the best vector is final.

---
 rtl/me_pkg.sv | 19 +
 rtl/me_pe_sched.sv | 34 +++
 rtl/me_control.sv | 117 +++++++++++
 tb/tb_me_control.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants and state type for the motion-estimation sequencer.
package me_pkg;

  localparam int NUM_PE   = 16;
  localparam int NUM_ROWS = 16;
  localparam int BLK_PIX  = 256;
  localparam int CNT_W    = 13;

  localparam logic [CNT_W-1:0] RESULT_LAT = 13'd256;
  localparam logic [CNT_W-1:0] SWEEP_LEN  = 13'(NUM_ROWS * BLK_PIX);
  localparam logic [CNT_W-1:0] LAST_COUNT = 13'd4113;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/me_pe_sched.sv
// Combinational decode of the sweep counter into per-PE accumulate/clear
// windows and the finished-result strobe with its PE index and row.
module me_pe_sched
  import me_pkg::*;
(
  input  logic [CNT_W-1:0]  count_i,
  input  logic              en_i,
  output logic [NUM_PE-1:0] pe_acc_o,
  output logic [NUM_PE-1:0] pe_clr_o,
  output logic              pflag_o,
  output logic [3:0]        pe_idx_o,
  output logic [3:0]        row_o
);

  logic [CNT_W-1:0] res_w;

  // PE k runs k cycles behind PE 0, so its window is the count shifted by k.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
      logic [CNT_W-1:0] rel_w;
      assign rel_w        = count_i - CNT_W'(gi);
      assign pe_acc_o[gi] = en_i && (count_i >= CNT_W'(gi)) && (rel_w < SWEEP_LEN);
      assign pe_clr_o[gi] = pe_acc_o[gi] && (rel_w[7:0] == 8'd0);
    end
  endgenerate

  assign res_w    = count_i - RESULT_LAT;
  assign pflag_o  = en_i && (count_i >= RESULT_LAT) && (res_w < SWEEP_LEN) &&
                    (res_w[7:4] == 4'd0);
  assign pe_idx_o = res_w[3:0];
  assign row_o    = res_w[11:8];

endmodule

// File: rtl/me_control.sv
// Motion-estimation sweep sequencer: FSM, sweep counter and registered result tags.
// Optional ME_CTRL_STALL_EN adds a 'hold' input that freezes the sweep while in RUN.
module me_control
  import me_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
`ifdef ME_CTRL_STALL_EN
  input  logic              hold,
`endif
  output logic [NUM_PE-1:0] PEacc,
  output logic [NUM_PE-1:0] PEclr,
  output logic [7:0]        AddressR,
  output logic              pflag,
  output logic [NUM_PE-1:0] PEready,
  output logic [3:0]        vectorX,
  output logic [3:0]        vectorY,
  output logic              CompStart,
  output logic              done
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NUM_PE-1:0] pe_ready_q, pe_ready_d;
  logic [3:0]        vec_x_q, vec_x_d;
  logic [3:0]        vec_y_q, vec_y_d;
  logic              run_w, stall_w, en_w;
  logic              sched_pflag_w;
  logic [3:0]        sched_idx_w, sched_row_w;
  logic [NUM_PE-1:0] sched_acc_w, sched_clr_w;

`ifdef ME_CTRL_STALL_EN
  assign stall_w = hold && run_w;
`else
  assign stall_w = 1'b0;
`endif
  assign en_w = run_w && !stall_w;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!stall_w && (count_q == LAST_COUNT)) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_w     = (state_q == RUN);
    CompStart = (state_q == RUN) || (state_q == DONE);
    done      = (state_q == DONE);
  end

  // Counter stops at LAST_COUNT, which is also where RUN hands over to DONE.
  always_comb begin
    count_d = count_q;
    if (state_q == IDLE) count_d = '0;
    else if (en_w && (count_q != LAST_COUNT)) count_d = count_q + 13'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  me_pe_sched u_sched (
    .count_i  (count_q),
    .en_i     (en_w),
    .pe_acc_o (sched_acc_w),
    .pe_clr_o (sched_clr_w),
    .pflag_o  (sched_pflag_w),
    .pe_idx_o (sched_idx_w),
    .row_o    (sched_row_w)
  );

  // A tag captured just before a stall is kept and shown once the stall ends.
  always_comb begin
    pe_ready_d = pe_ready_q;
    vec_x_d    = vec_x_q;
    vec_y_d    = vec_y_q;
    if (!stall_w) begin
      pe_ready_d = sched_pflag_w ? (NUM_PE'(1) << sched_idx_w) : '0;
      if (sched_pflag_w) begin
        vec_x_d = sched_idx_w;
        vec_y_d = sched_row_w;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pe_ready_q <= '0;
      vec_x_q    <= '0;
      vec_y_q    <= '0;
    end else begin
      pe_ready_q <= pe_ready_d;
      vec_x_q    <= vec_x_d;
      vec_y_q    <= vec_y_d;
    end
  end

  assign PEacc    = sched_acc_w;
  assign PEclr    = sched_clr_w;
  assign pflag    = sched_pflag_w;
  assign PEready  = pe_ready_q & {NUM_PE{!stall_w}};
  assign vectorX  = vec_x_q;
  assign vectorY  = vec_y_q;
  assign AddressR = (run_w && (count_q < SWEEP_LEN)) ? count_q[7:0] : 8'd0;

endmodule

// File: tb/tb_me_control.sv
// Directed bench for me_control with a small Comparator/PE-sum model.
// Build with ME_CTRL_STALL_EN defined to also exercise the hold input.
module tb_me_control;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
`ifdef ME_CTRL_STALL_EN
  logic        hold = 1'b0;
`endif
  logic [15:0] PEacc, PEclr, PEready;
  logic [7:0]  AddressR;
  logic        pflag, CompStart, done;
  logic [3:0]  vectorX, vectorY;

  int checks = 0;
  int errors = 0;
  logic [64:0] trace_mem [1000];

  me_control dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
`ifdef ME_CTRL_STALL_EN
    .hold      (hold),
`endif
    .PEacc     (PEacc),
    .PEclr     (PEclr),
    .AddressR  (AddressR),
    .pflag     (pflag),
    .PEready   (PEready),
    .vectorX   (vectorX),
    .vectorY   (vectorY),
    .CompStart (CompStart),
    .done      (done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference PE sums: unique minimum at PE 5, row 9.
  function automatic logic [7:0] pe_sum(input logic [3:0] x, input logic [3:0] y);
    if (x == 4'd5 && y == 4'd9) return 8'd3;
    return 8'd40 + {4'd0, x} + {4'd0, y};
  endfunction

  // Launches from IDLE and runs until done; returns cycle count from the
  // first RUN cycle, number of result tags, ordering/stall violations, best vector.
  task automatic run_search(input int hold_at, input int hold_len, output int cyc,
                            output int nev, output int bad,
                            output logic [3:0] mx, output logic [3:0] my);
    logic [7:0] best;
    int ek, er;
    best = 8'hff; mx = 4'd0; my = 4'd0; ek = 0; er = 0; nev = 0; bad = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 6000) begin
`ifdef ME_CTRL_STALL_EN
      hold = (cyc >= hold_at && cyc < hold_at + hold_len);
`endif
      #1;
`ifdef ME_CTRL_STALL_EN
      if (hold && ({PEacc, PEclr, pflag, PEready} !== '0)) bad++;
`endif
      if (PEready !== 16'd0) begin
        nev++;
        if (PEready !== (16'd1 << ek) || vectorX !== 4'(ek) || vectorY !== 4'(er)) bad++;
        if (pe_sum(vectorX, vectorY) < best) begin
          best = pe_sum(vectorX, vectorY);
          mx = vectorX;
          my = vectorY;
        end
        ek++;
        if (ek == 16) begin
          ek = 0;
          er++;
        end
      end
      step();
      cyc++;
    end
`ifdef ME_CTRL_STALL_EN
    hold = 1'b0;
`endif
    if (hold_at < 0) bad++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({PEacc, PEclr, AddressR, pflag, PEready, vectorX, vectorY, CompStart, done} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %h want 0", i,
                 {PEacc, PEclr, AddressR, pflag, PEready, vectorX, vectorY, CompStart, done});
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if (CompStart !== 1'b1 || PEclr !== 16'h0001 || PEacc !== 16'h0001 || AddressR !== 8'd0) begin
      errors++;
      $display("FAIL run_after_release got CompStart=%b PEclr=%h PEacc=%h want 1 0001 0001",
               CompStart, PEclr, PEacc);
    end
    start = 1'b0;
    $display("test_reset complete");
  endtask

  // Continues the run started by test_reset (count 0 on entry).
  task automatic test_pe_windows();
    logic exp_b;
    logic [7:0] exp_a;
    for (int t = 0; t <= 520; t++) begin
      if (t > 0) step();
      if (t == 2 || t == 3 || t == 4 || t == 258 || t == 259 || t == 515) begin
        exp_b = (t % 256 == 3);
        checks++;
        if (PEclr[3] !== exp_b) begin
          errors++;
          $display("FAIL peclr3 count %0d got %b want %b", t, PEclr[3], exp_b);
        end
      end
      if (t == 14 || t == 15 || t == 100 || t == 270) begin
        exp_b = (t != 14);
        checks++;
        if (PEacc[15] !== exp_b) begin
          errors++;
          $display("FAIL peacc15 count %0d got %b want %b", t, PEacc[15], exp_b);
        end
      end
      if (t == 255 || t == 256 || t == 511 || t == 512) begin
        exp_a = (t % 256 == 255) ? 8'd255 : 8'd0;
        checks++;
        if (AddressR !== exp_a) begin
          errors++;
          $display("FAIL addr_wrap count %0d got %0d want %0d", t, AddressR, exp_a);
        end
      end
    end
    $display("test_pe_windows complete");
  endtask

  task automatic test_first_results();
    logic exp_pf;
    logic [15:0] exp_rdy;
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t <= 272; t++) begin
      if (t > 0) step();
      if (t >= 255) begin
        exp_pf  = (t >= 256 && t <= 271);
        exp_rdy = (t >= 257) ? (16'd1 << (t - 257)) : 16'd0;
        checks++;
        if (pflag !== exp_pf) begin
          errors++;
          $display("FAIL pflag count %0d got %b want %b", t, pflag, exp_pf);
        end
        checks++;
        if (PEready !== exp_rdy) begin
          errors++;
          $display("FAIL peready count %0d got %h want %h", t, PEready, exp_rdy);
        end
        if (t >= 257) begin
          checks++;
          if (vectorX !== 4'(t - 257) || vectorY !== 4'd0) begin
            errors++;
            $display("FAIL vector count %0d got %0d,%0d want %0d,0", t, vectorX, vectorY, t - 257);
          end
        end
      end
    end
    $display("test_first_results complete");
  endtask

  task automatic test_reset_restart();
    int mism;
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t <= 1000; t++) begin
      if (t > 0) step();
      if (t < 1000)
        trace_mem[t] = {PEacc, PEclr, AddressR, pflag, PEready, vectorX, vectorY};
    end
    checks++;
    if (AddressR !== 8'd232 || PEacc !== 16'hffff || PEclr !== 16'h0 || pflag !== 1'b0 ||
        CompStart !== 1'b1) begin
      errors++;
      $display("FAIL count1000 got addr=%0d acc=%h clr=%h pflag=%b cs=%b want 232 ffff 0 0 1",
               AddressR, PEacc, PEclr, pflag, CompStart);
    end
    reset = 1'b1;
    step();
    checks++;
    if (CompStart !== 1'b0 || PEready !== 16'h0 || PEacc !== 16'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got cs=%b rdy=%h acc=%h done=%b want 0 0 0 0",
               CompStart, PEready, PEacc, done);
    end
    reset = 1'b0;
    step();
    checks++;
    if (CompStart !== 1'b0 || PEready !== 16'h0 || AddressR !== 8'd0) begin
      errors++;
      $display("FAIL idle_after_reset got cs=%b rdy=%h addr=%0d want 0 0 0",
               CompStart, PEready, AddressR);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    mism = 0;
    for (int t = 0; t < 1000; t++) begin
      if (t > 0) step();
      if ({PEacc, PEclr, AddressR, pflag, PEready, vectorX, vectorY} !== trace_mem[t]) mism++;
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL restart_trace got %0d differing cycles want 0", mism);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    $display("test_reset_restart complete");
  endtask

  task automatic test_full_search();
    int cyc, nev, bad;
    logic [3:0] mx, my;
    run_search(100000, 0, cyc, nev, bad, mx, my);
    checks++;
    if (cyc != 4114) begin
      errors++;
      $display("FAIL done_latency got %0d want 4114", cyc);
    end
    checks++;
    if (nev != 256 || bad != 0) begin
      errors++;
      $display("FAIL result_tags got %0d tags %0d bad want 256 0", nev, bad);
    end
    checks++;
    if (mx !== 4'd5 || my !== 4'd9) begin
      errors++;
      $display("FAIL motion got %0d,%0d want 5,9", mx, my);
    end
    checks++;
    if (done !== 1'b1 || CompStart !== 1'b1 || {PEacc, PEclr, pflag, PEready} !== '0 ||
        vectorX !== 4'd15 || vectorY !== 4'd15) begin
      errors++;
      $display("FAIL done_state got done=%b cs=%b acc=%h rdy=%h vec=%0d,%0d want 1 1 0 0 15,15",
               done, CompStart, PEacc, PEready, vectorX, vectorY);
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (done !== 1'b1 || PEacc !== 16'h0) begin
      errors++;
      $display("FAIL done_hold_start got done=%b acc=%h want 1 0", done, PEacc);
    end
    start = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || CompStart !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle got done=%b cs=%b want 0 0", done, CompStart);
    end
    $display("test_full_search complete cycles=%0d motion=%0d,%0d", cyc, mx, my);
  endtask

`ifdef ME_CTRL_STALL_EN
  task automatic test_stall();
    int cyc, nev, bad;
    logic [3:0] mx, my;
    run_search(300, 10, cyc, nev, bad, mx, my);
    checks++;
    if (cyc != 4124) begin
      errors++;
      $display("FAIL stall_latency got %0d want 4124", cyc);
    end
    checks++;
    if (nev != 256 || bad != 0 || mx !== 4'd5 || my !== 4'd9) begin
      errors++;
      $display("FAIL stall_results got %0d tags %0d bad motion %0d,%0d want 256 0 5,9",
               nev, bad, mx, my);
    end
    start = 1'b0;
    step();
    $display("test_stall complete cycles=%0d", cyc);
  endtask
`endif

  initial begin
    test_reset();
    test_pe_windows();
    test_first_results();
    test_reset_restart();
    test_full_search();
`ifdef ME_CTRL_STALL_EN
    test_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
